arb_mux_n: RTL and testbench



---
 rtl/arb_mux_n.sv | 135 +++++++++++++
 tb/tb_arb_mux_n.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux_n.sv
// arb_mux_n: CH-way operand/result multiplexer for the EXE stage.
// Round-robin or forced channel selection feeds one registered output beat
// behind a valid/ready handshake. in_ready is combinational from the request
// side; in_data only ever reaches the output register, never an output port
// combinationally.
module arb_mux_n #(
  parameter  int ARQ = 16,
  parameter  int CH  = 4,
  localparam int SW  = $clog2(CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     in_valid,
  input  logic [CH*ARQ-1:0] in_data,
  output logic [CH-1:0]     in_ready,
  input  logic              force_en,
  input  logic [SW-1:0]     force_sel,
  output logic              out_valid,
  output logic [ARQ-1:0]    out_data,
  output logic [SW-1:0]     out_ch,
  input  logic              out_ready
);

  // One extra bit so force_sel can be compared against CH even when CH is a
  // power of two (then every force_sel value is in range).
  localparam int CW = SW + 1;

  if (CH < 2 || CH > 8) begin : g_bad_ch
    $error("arb_mux_n: CH must be in 2..8");
  end
  if (ARQ < 1) begin : g_bad_arq
    $error("arb_mux_n: ARQ must be at least 1");
  end

  // Output register state and its next-state values.
  logic            out_valid_reg, out_valid_next;
  logic [ARQ-1:0]  out_data_reg,  out_data_next;
  logic [SW-1:0]   out_ch_reg,    out_ch_next;
  logic [SW-1:0]   ptr_reg,       ptr_next;

  // Request-side decode.
  logic [ARQ-1:0]  ch_data [CH];
  logic [CH-1:0]   force_hit;
  logic [CH-1:0]   elig;
  logic [CH-1:0]   upper;
  logic            force_in_range;
  logic            load;

  // Grant selection.
  logic            upper_any;
  logic [SW-1:0]   upper_idx;
  logic            elig_any;
  logic [SW-1:0]   elig_idx;
  logic            gnt_valid;
  logic [SW-1:0]   gnt_idx;
  logic            xfer;

  assign force_in_range = ({1'b0, force_sel} < CW'(CH));
  assign load           = !out_valid_reg || out_ready;

  // Per-channel slicing, eligibility, the "at or above ptr" half of the
  // rotating scan, and the one-hot accept.
  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    assign ch_data[gi]   = in_data[gi*ARQ +: ARQ];
    assign force_hit[gi] = force_in_range && (force_sel == SW'(gi));
    assign elig[gi]      = in_valid[gi] && (force_en ? force_hit[gi] : 1'b1);
    assign upper[gi]     = elig[gi] && (SW'(gi) >= ptr_reg);
    assign in_ready[gi]  = rst_n && load && gnt_valid && (gnt_idx == SW'(gi));
  end

  // Two lowest-index priority encoders: one over channels at or above ptr,
  // one over all eligible channels. The first wins when it finds anything,
  // which reproduces the circular scan ptr, ptr+1, ..., CH-1, 0, ..., ptr-1.
  always_comb begin
    upper_any = 1'b0;
    upper_idx = '0;
    elig_any  = 1'b0;
    elig_idx  = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (upper[i]) begin
        upper_any = 1'b1;
        upper_idx = SW'(i);
      end
      if (elig[i]) begin
        elig_any = 1'b1;
        elig_idx = SW'(i);
      end
    end
  end

  // In force mode at most one channel is eligible, so the same encoders
  // yield force_sel directly.
  assign gnt_valid = elig_any;
  assign gnt_idx   = upper_any ? upper_idx : elig_idx;
  assign xfer      = load && gnt_valid;

  // Next-state of the output register and round-robin pointer. A fill
  // replaces the held beat even when it is draining in the same cycle.
  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_ch_next    = out_ch_reg;
    ptr_next       = ptr_reg;
    if (xfer) begin
      out_valid_next = 1'b1;
      out_data_next  = ch_data[gnt_idx];
      out_ch_next    = gnt_idx;
      if (!force_en) begin
        ptr_next = (gnt_idx == SW'(CH - 1)) ? '0 : gnt_idx + SW'(1);
      end
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  // State register with synchronous active-low reset; reset drops any held beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      ptr_reg       <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_ch_reg    <= out_ch_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_arb_mux_n.sv
// Testbench for arb_mux_n: bench-side arbitration model plus a scoreboard of
// expected beats; each scenario task checks accepts and registered outputs.
module tb_arb_mux_n;

  localparam int ARQ = 16;
  localparam int CH  = 4;
  localparam int SW  = $clog2(CH);

  typedef struct {
    logic [SW-1:0]  ch;
    logic [ARQ-1:0] data;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic [CH-1:0]     in_valid;
  logic [CH*ARQ-1:0] in_data;
  logic [CH-1:0]     in_ready;
  logic              force_en;
  logic [SW-1:0]     force_sel;
  logic              out_valid;
  logic [ARQ-1:0]    out_data;
  logic [SW-1:0]     out_ch;
  logic              out_ready;

  arb_mux_n #(.ARQ(ARQ), .CH(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .force_en  (force_en),
    .force_sel (force_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters, scoreboard and bench model state.
  int             n_cmp = 0;
  int             n_err = 0;
  beat_t          sb[$];
  int             m_ptr = 0;
  logic           m_ov  = 1'b0;
  logic [ARQ-1:0] m_od  = '0;
  logic [SW-1:0]  m_och = '0;
  logic [CH-1:0]  obs_ready;
  logic [CH-1:0]  exp_ready;
  logic           xfer_exp;

  // Reference arbiter: walk the circle starting at the bench's pointer.
  function automatic int model_grant();
    if (force_en) begin
      if (int'(force_sel) < CH && in_valid[force_sel]) return int'(force_sel);
      return -1;
    end
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (m_ptr + k) % CH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_data(input logic [ARQ-1:0] base);
    for (int i = 0; i < CH; i++) in_data[i*ARQ +: ARQ] = base + ARQ'(i);
  endtask

  // One clock: sample in_ready mid-cycle, predict the accept, push the
  // expected beat, then advance the model at the edge.
  task automatic tick();
    int    g;
    logic  fen;
    beat_t b;
    @(negedge clk);
    obs_ready = in_ready;
    fen       = force_en;
    g         = model_grant();
    exp_ready = '0;
    xfer_exp  = 1'b0;
    b.ch      = '0;
    b.data    = '0;
    if (rst_n && (!m_ov || out_ready) && g >= 0) begin
      exp_ready[g] = 1'b1;
      xfer_exp     = 1'b1;
      b.ch         = SW'(g);
      b.data       = in_data[g*ARQ +: ARQ];
      sb.push_back(b);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_ov = 1'b0; m_od = '0; m_och = '0; m_ptr = 0;
    end else if (xfer_exp) begin
      m_ov = 1'b1; m_od = b.data; m_och = b.ch;
      if (!fen) m_ptr = (g + 1) % CH;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    beat_t b;
    rst_n = 1'b0; in_valid = '1; set_data(16'h1000);
    out_ready = 1'b1; force_en = 1'b0; force_sel = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (obs_ready !== 4'b0000) begin
        n_err++; $display("FAIL reset_ready: got %b want 0000", obs_ready);
      end
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_ch !== 2'd0) begin
        n_err++;
        $display("FAIL reset_out: got v=%b d=%h ch=%0d want v=0 d=0000 ch=0", out_valid, out_data, out_ch);
      end
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (obs_ready !== 4'b0001) begin
      n_err++; $display("FAIL reset_first_grant: got %b want 0001", obs_ready);
    end
    if (xfer_exp) begin
      b = sb.pop_front();
      $display("beat reset_release ch=%0d data=%h", out_ch, out_data);
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 16'h1000) begin
        n_err++;
        $display("FAIL reset_first_beat: got v=%b ch=%0d d=%h want v=1 ch=0 d=1000", out_valid, out_ch, out_data);
      end
    end
  endtask

  task automatic test_full_contention();
    beat_t b;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    in_valid = 4'b1111; set_data(16'h1000); out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++;
      if (obs_ready !== exp_ready) begin
        n_err++; $display("FAIL contention_ready[%0d]: got %b want %b", k, obs_ready, exp_ready);
      end
      if (xfer_exp) begin
        b = sb.pop_front();
        $display("beat contention ch=%0d data=%h", out_ch, out_data);
        n_cmp++;
        if (out_valid !== 1'b1 || out_ch !== b.ch || out_data !== b.data ||
            out_ch !== SW'(k % CH) || out_data !== 16'h1000 + 16'(k % CH)) begin
          n_err++;
          $display("FAIL contention_beat[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                   k, out_valid, out_ch, out_data, k % CH, 16'h1000 + 16'(k % CH));
        end
      end
    end
  endtask

  task automatic test_sparse_wrap();
    beat_t b;
    int    want [3] = '{0, 2, 0};
    in_valid = 4'b0100; tick();           // grant 2 moves ptr to 3
    if (xfer_exp) void'(sb.pop_front());
    in_valid = 4'b0101; set_data(16'h3000);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (obs_ready !== exp_ready) begin
        n_err++; $display("FAIL sparse_ready[%0d]: got %b want %b", k, obs_ready, exp_ready);
      end
      if (xfer_exp) begin
        b = sb.pop_front();
        $display("beat sparse ch=%0d data=%h", out_ch, out_data);
        n_cmp++;
        if (out_ch !== SW'(want[k]) || out_data !== b.data || out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL sparse_beat[%0d]: got ch=%0d d=%h want ch=%0d d=%h", k, out_ch, out_data, want[k], b.data);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    beat_t b;
    in_valid = 4'b0001; in_data[0 +: ARQ] = 16'hBEEF; out_ready = 1'b1;
    tick();
    if (xfer_exp) void'(sb.pop_front());
    in_valid = 4'b0010; in_data[ARQ +: ARQ] = 16'h1111; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (obs_ready !== 4'b0000) begin
        n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, obs_ready);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_ch !== 2'd0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d want v=1 d=beef ch=0", k, out_valid, out_data, out_ch);
      end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (obs_ready !== 4'b0010) begin
      n_err++; $display("FAIL bp_release_ready: got %b want 0010", obs_ready);
    end
    if (xfer_exp) begin
      b = sb.pop_front();
      $display("beat backpressure ch=%0d data=%h", out_ch, out_data);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 16'h1111 || out_ch !== 2'd1) begin
        n_err++;
        $display("FAIL bp_release_beat: got v=%b d=%h ch=%0d want v=1 d=1111 ch=1", out_valid, out_data, out_ch);
      end
    end
    in_valid = 4'b0000;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 16'h1111) begin
      n_err++; $display("FAIL bp_drain: got v=%b d=%h want v=0 d=1111", out_valid, out_data);
    end
  endtask

  task automatic test_force();
    beat_t b;
    in_valid = 4'b0001; set_data(16'h2000); tick();   // ptr moves to 1
    if (xfer_exp) void'(sb.pop_front());
    in_valid = 4'b1111; force_en = 1'b1; force_sel = 2'd2;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (obs_ready !== 4'b0100) begin
        n_err++; $display("FAIL force_ready[%0d]: got %b want 0100", k, obs_ready);
      end
      if (xfer_exp) begin
        b = sb.pop_front();
        $display("beat force ch=%0d data=%h", out_ch, out_data);
        n_cmp++;
        if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 16'h2002) begin
          n_err++;
          $display("FAIL force_beat[%0d]: got ch=%0d d=%h want ch=2 d=2002", k, out_ch, out_data);
        end
      end
    end
    force_en = 1'b0;                                   // ptr must still be 1
    tick();
    n_cmp++;
    if (obs_ready !== 4'b0010) begin
      n_err++; $display("FAIL force_ptr_kept: got %b want 0010", obs_ready);
    end
    if (xfer_exp) void'(sb.pop_front());
    force_en = 1'b1; force_sel = 2'd2; in_valid = 4'b1011;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (obs_ready !== 4'b0000 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL force_idle[%0d]: got ready=%b v=%b want ready=0000 v=0", k, obs_ready, out_valid);
      end
    end
    force_en = 1'b0; force_sel = '0;
  endtask

  task automatic test_reset_mid();
    beat_t b;
    in_valid = 4'b0010; set_data(16'h4000); out_ready = 1'b1;
    tick();                                            // grant 1, ptr 2
    if (xfer_exp) void'(sb.pop_front());
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'h4001) begin
      n_err++; $display("FAIL mid_setup: got v=%b d=%h want v=1 d=4001", out_valid, out_data);
    end
    rst_n = 1'b0; in_valid = 4'b1111;
    tick();
    n_cmp++;
    if (obs_ready !== 4'b0000 || out_valid !== 1'b0 || out_data !== 16'h0000 || out_ch !== 2'd0) begin
      n_err++;
      $display("FAIL mid_reset: got ready=%b v=%b d=%h ch=%0d want 0000 0 0000 0", obs_ready, out_valid, out_data, out_ch);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (obs_ready !== 4'b0001) begin
      n_err++; $display("FAIL mid_first_grant: got %b want 0001", obs_ready);
    end
    if (xfer_exp) begin
      b = sb.pop_front();
      $display("beat reset_mid ch=%0d data=%h", out_ch, out_data);
      n_cmp++;
      if (out_ch !== 2'd0 || out_data !== 16'h4000 || out_data !== b.data) begin
        n_err++; $display("FAIL mid_first_beat: got ch=%0d d=%h want ch=0 d=4000", out_ch, out_data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = '0; in_data = '0; force_en = 1'b0;
    force_sel = '0; out_ready = 1'b1;
    test_reset();
    test_full_contention();
    test_sparse_wrap();
    test_backpressure();
    test_force();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_left: got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
